fir_wb_axis_host: RTL and testbench

Host-side initiator for the FIR accelerator. It acts as Wishbone master to program the 11 tap coefficients and set ap_start, then acts as AXI-Stream source for input samples (ss_*) and AXI-Stream sink for results (sm_*). Per run it reports a result count, a checksum, and tlast and timeout error flags. It sits between the tap/sample ROMs (or CPU-loaded buffers) and the fir block on the user-project bus.

---
 rtl/fir_wb_axis_host.sv | 217 +++++++++++++++++++++
 tb/tb_fir_wb_axis_host.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_wb_axis_host.sv
// fir_wb_axis_host: host-side sequencer for the FIR accelerator.
// Programs the taps and ap_start over Wishbone, then streams samples out on
// ss_* and collects results on sm_*, keeping a result checksum and error flags.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for the first start after reset
// TAP_WR   | Wishbone write of tap k, held until ack
// TAP_GAP  | one idle bus cycle between writes, k advances
// CTRL_WR  | Wishbone write of 1 to ap_ctrl, held until ack
// CTRL_GAP | one idle bus cycle before streaming
// STREAM   | samples out on ss_*, results in on sm_*
// DONE     | run finished or aborted; checksum and flags held
module fir_wb_axis_host #(
    parameter int          N_TAP          = 11,
    parameter int          DATA_LEN       = 50,
    parameter int          IDX_W          = 8,
    parameter logic [31:0] ADDR_AP_CTRL   = 32'h20,
    parameter logic [31:0] ADDR_TAP_BEGIN = 32'h40,
    parameter int          TIMEOUT        = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] tap_idx,
    input  logic [31:0]      tap_val,
    output logic [IDX_W-1:0] smp_idx,
    input  logic [31:0]      smp_val,
    output logic             wbs_cyc_i,
    output logic             wbs_stb_i,
    output logic             wbs_we_i,
    output logic [3:0]       wbs_sel_i,
    output logic [31:0]      wbs_adr_i,
    output logic [31:0]      wbs_dat_i,
    input  logic             wbs_ack_o,
    output logic             ss_tvalid,
    input  logic             ss_tready,
    output logic [31:0]      ss_tdata,
    output logic             ss_tlast,
    input  logic             sm_tvalid,
    output logic             sm_tready,
    input  logic [31:0]      sm_tdata,
    input  logic             sm_tlast,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_idx,
    output logic [31:0]      res_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum,
    output logic             tlast_err,
    output logic             timeout_err
);

    localparam int               WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(N_TAP - 1);
    localparam logic [IDX_W-1:0] N_LAST  = IDX_W'(DATA_LEN - 1);
    localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        TAP_WR,
        TAP_GAP,
        CTRL_WR,
        CTRL_GAP,
        STREAM,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] in_cnt;
    logic [IDX_W-1:0] out_cnt;
    logic [WD_W-1:0]  wdog;
    logic             wb_req;

    logic ss_beat;
    logic sm_beat;
    logic wb_ack;
    logic progress;
    logic wd_live;
    logic wd_fire;

    assign ss_beat  = ss_tvalid & ss_tready;
    assign sm_beat  = sm_tvalid & sm_tready;
    assign wb_ack   = wb_req & wbs_ack_o;
    assign progress = wb_ack | ss_beat | sm_beat;
    assign wd_live  = (state == TAP_WR) | (state == CTRL_WR) | (state == STREAM);
    // wdog is a down-counter reloaded on progress; reaching zero with no
    // progress in a watched state means TIMEOUT idle cycles have elapsed.
    assign wd_fire  = wd_live & ~progress & (wdog == '0);

    // Bus and stream payloads come straight from registered state and the
    // combinational ROMs, so they cannot change while a handshake is pending.
    assign wbs_cyc_i = wb_req;
    assign wbs_stb_i = wb_req;
    assign wbs_we_i  = wb_req;
    assign wbs_sel_i = 4'hF;
    assign wbs_adr_i = !wb_req            ? 32'h0 :
                       (state == CTRL_WR) ? ADDR_AP_CTRL :
                                            ADDR_TAP_BEGIN + (32'(k) << 2);
    assign wbs_dat_i = !wb_req            ? 32'h0 :
                       (state == CTRL_WR) ? 32'h1 : tap_val;
    assign tap_idx   = k;
    assign smp_idx   = in_cnt;
    assign ss_tdata  = ss_tvalid ? smp_val : 32'h0;
    assign ss_tlast  = ss_tvalid & (in_cnt == N_LAST);

    // Run sequencer with watchdog and result bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            wdog        <= '0;
            wb_req      <= 1'b0;
            ss_tvalid   <= 1'b0;
            sm_tready   <= 1'b0;
            res_valid   <= 1'b0;
            res_idx     <= '0;
            res_data    <= 32'h0;
            busy        <= 1'b0;
            done        <= 1'b0;
            checksum    <= 32'h0;
            tlast_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            res_valid <= 1'b0;

            if (wd_live) begin
                if (progress) begin
                    wdog <= WD_LOAD;
                end else if (wdog != '0) begin
                    wdog <= wdog - 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= TAP_WR;
                        wb_req      <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        k           <= '0;
                        in_cnt      <= '0;
                        out_cnt     <= '0;
                        wdog        <= WD_LOAD;
                        checksum    <= 32'h0;
                        tlast_err   <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                TAP_WR: begin
                    if (wb_ack) begin
                        wb_req <= 1'b0;
                        state  <= TAP_GAP;
                    end
                end
                TAP_GAP: begin
                    k      <= k + 1'b1;
                    wb_req <= 1'b1;
                    state  <= (k == K_LAST) ? CTRL_WR : TAP_WR;
                end
                CTRL_WR: begin
                    if (wb_ack) begin
                        wb_req <= 1'b0;
                        state  <= CTRL_GAP;
                    end
                end
                CTRL_GAP: begin
                    state     <= STREAM;
                    ss_tvalid <= 1'b1;
                    sm_tready <= 1'b1;
                end
                STREAM: begin
                    if (ss_beat) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == N_LAST) begin
                            ss_tvalid <= 1'b0;
                        end
                    end
                    if (sm_beat) begin
                        res_valid <= 1'b1;
                        res_idx   <= out_cnt;
                        res_data  <= sm_tdata;
                        checksum  <= checksum + sm_tdata;
                        out_cnt   <= out_cnt + 1'b1;
                        if (sm_tlast != (out_cnt == N_LAST)) begin
                            tlast_err <= 1'b1;
                        end
                        // The last result ends the run even if samples remain.
                        if (out_cnt == N_LAST) begin
                            ss_tvalid <= 1'b0;
                            sm_tready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (wd_fire) begin
                wb_req      <= 1'b0;
                ss_tvalid   <= 1'b0;
                sm_tready   <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
                timeout_err <= 1'b1;
                state       <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_fir_wb_axis_host.sv
// tb_fir_wb_axis_host: directed bench for the FIR host sequencer.
// The bench plays Wishbone slave, ss_* sink and sm_* source, with tap and
// sample ROMs and a golden convolution computed locally.
module tb_fir_wb_axis_host;

    localparam int N_TAP    = 11;
    localparam int DATA_LEN = 50;
    localparam int IDX_W    = 8;
    localparam int TIMEOUT  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IDX_W-1:0] tap_idx;
    logic [31:0]      tap_val;
    logic [IDX_W-1:0] smp_idx;
    logic [31:0]      smp_val;
    logic             wbs_cyc_i;
    logic             wbs_stb_i;
    logic             wbs_we_i;
    logic [3:0]       wbs_sel_i;
    logic [31:0]      wbs_adr_i;
    logic [31:0]      wbs_dat_i;
    logic             wbs_ack_o;
    logic             ss_tvalid;
    logic             ss_tready;
    logic [31:0]      ss_tdata;
    logic             ss_tlast;
    logic             sm_tvalid;
    logic             sm_tready;
    logic [31:0]      sm_tdata;
    logic             sm_tlast;
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic [31:0]      res_data;
    logic             busy;
    logic             done;
    logic [31:0]      checksum;
    logic             tlast_err;
    logic             timeout_err;

    fir_wb_axis_host #(
        .N_TAP(N_TAP), .DATA_LEN(DATA_LEN), .IDX_W(IDX_W),
        .ADDR_AP_CTRL(32'h20), .ADDR_TAP_BEGIN(32'h40), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .tap_idx(tap_idx), .tap_val(tap_val),
        .smp_idx(smp_idx), .smp_val(smp_val),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
        .busy(busy), .done(done), .checksum(checksum),
        .tlast_err(tlast_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          taps [N_TAP] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int          xs   [DATA_LEN];
    logic [31:0] tap_rom [N_TAP];
    logic [31:0] smp_rom [DATA_LEN];
    logic [31:0] gold    [DATA_LEN];

    // Combinational ROMs, zero outside their range.
    always_comb begin
        tap_val = 32'h0;
        for (int i = 0; i < N_TAP; i++)
            if (int'(tap_idx) == i) tap_val = tap_rom[i];
    end

    // Sample ROM read port.
    always_comb begin
        smp_val = 32'h0;
        for (int i = 0; i < DATA_LEN; i++)
            if (int'(smp_idx) == i) smp_val = smp_rom[i];
    end

    typedef struct {
        int ack_dly;   // stb cycles without ack before the ack cycle
        int ss_gap;    // ss_tready low every ss_gap-th cycle (0: never)
        int sm_gap;    // sm_tvalid held off every sm_gap-th cycle (0: never)
        int ss_stop;   // sink accepts only this many samples
        int sm_causal; // result n offered only after sample n was taken
        int sm_en;     // results offered at all
        int bad_idx;   // result whose sm_tlast is inverted (-1: none)
        int exp_wb;
        int exp_ss;
        int exp_res;
        int exp_tlast;
        int exp_to;
        int exp_ssv;   // cycles with ss_tvalid high (-1: not checked)
    } vec_t;

    vec_t vecs [8];

    int checks = 0;
    int errors = 0;

    // Per-run bench model state
    int          ack_dly, ss_gap, sm_gap, ss_stop, sm_causal, sm_en, bad_idx;
    int          cyc_n;
    int          wb_n, wb_wait, wb_idle, wb_stab_err, wb_gap_err, wb_sel_err;
    logic        wb_seen_any;
    logic [31:0] cur_adr, cur_dat;
    logic [31:0] wb_adr [16];
    logic [31:0] wb_dat [16];
    int          ss_n, ss_err, ss_vcyc;
    logic        ss_hold, ss_hold_last;
    logic [31:0] ss_hold_dat;
    int          sm_n;
    logic        sm_pend;
    int          res_n, res_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_run();
        cyc_n = 0;
        wb_n = 0; wb_wait = 0; wb_idle = 0;
        wb_stab_err = 0; wb_gap_err = 0; wb_sel_err = 0; wb_seen_any = 1'b0;
        ss_n = 0; ss_err = 0; ss_vcyc = 0; ss_hold = 1'b0;
        sm_n = 0; sm_pend = 1'b0;
        res_n = 0; res_err = 0;
        wbs_ack_o = 1'b0; ss_tready = 1'b0;
        sm_tvalid = 1'b0; sm_tdata = 32'h0; sm_tlast = 1'b0;
    endtask

    task automatic load_cfg(input vec_t v);
        ack_dly = v.ack_dly; ss_gap = v.ss_gap; sm_gap = v.sm_gap;
        ss_stop = v.ss_stop; sm_causal = v.sm_causal; sm_en = v.sm_en;
        bad_idx = v.bad_idx;
    endtask

    // One clock: observe DUT at the falling edge, drive inputs for the next rise.
    task automatic tick();
        @(negedge clk);
        cyc_n++;

        if (res_valid) begin
            if (res_n >= DATA_LEN) res_err++;
            else if (res_idx != 8'(res_n) || res_data != gold[res_n]) res_err++;
            res_n++;
        end

        wbs_ack_o = 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
            if (wb_wait == 0) begin
                cur_adr = wbs_adr_i;
                cur_dat = wbs_dat_i;
                if (wb_seen_any && wb_idle != 1) wb_gap_err++;
            end else if (wbs_adr_i != cur_adr || wbs_dat_i != cur_dat) begin
                wb_stab_err++;
            end
            if (wbs_sel_i != 4'hF || !wbs_we_i) wb_sel_err++;
            if (wb_wait == ack_dly) begin
                wbs_ack_o = 1'b1;
                if (wb_n < 16) begin
                    wb_adr[wb_n] = cur_adr;
                    wb_dat[wb_n] = cur_dat;
                end
                wb_n++;
                wb_wait = 0;
                wb_idle = 0;
                wb_seen_any = 1'b1;
            end else begin
                wb_wait++;
            end
        end else begin
            wb_wait = 0;
            wb_idle++;
        end

        if (!sm_pend) begin
            sm_tvalid = (sm_en != 0) && (sm_n < DATA_LEN) && (sm_causal == 0 || sm_n < ss_n)
                        && (sm_gap == 0 || (cyc_n % sm_gap) != 0);
            sm_tdata  = (sm_n < DATA_LEN) ? gold[sm_n] : 32'h0;
            sm_tlast  = (sm_n == DATA_LEN - 1) ^ (sm_n == bad_idx);
        end
        sm_pend = sm_tvalid && !sm_tready;
        if (sm_tvalid && sm_tready) sm_n++;

        if (ss_tvalid) begin
            ss_vcyc++;
            if (ss_hold && (ss_tdata != ss_hold_dat || ss_tlast != ss_hold_last)) ss_err++;
        end
        ss_tready = (ss_n < ss_stop) && (ss_gap == 0 || (cyc_n % ss_gap) != 0);
        if (ss_tvalid && ss_tready) begin
            if (ss_n >= DATA_LEN) ss_err++;
            else if (ss_tdata != smp_rom[ss_n] || ss_tlast != (ss_n == DATA_LEN - 1)) ss_err++;
            ss_n++;
            ss_hold = 1'b0;
        end else begin
            ss_hold      = ss_tvalid;
            ss_hold_dat  = ss_tdata;
            ss_hold_last = ss_tlast;
        end
    endtask

    function automatic logic [31:0] exp_sum(input int n);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < n; i++) s = s + gold[i];
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " ctrl_bits"},
              {wbs_cyc_i, wbs_stb_i, wbs_we_i, ss_tvalid, ss_tlast, sm_tready,
               res_valid, busy, done, tlast_err, timeout_err}, 0);
        check({tag, " wbs_adr_i"}, wbs_adr_i, 0);
        check({tag, " wbs_dat_i"}, wbs_dat_i, 0);
        check({tag, " wbs_sel_i"}, wbs_sel_i, 4'hF);
        check({tag, " indices"}, {tap_idx, smp_idx, res_idx}, 0);
        check({tag, " data_out"}, {ss_tdata, res_data}, 0);
        check({tag, " checksum"}, checksum, 0);
    endtask

    task automatic run_case(input int r, input vec_t v);
        int guard;
        int seq_err;
        string p;
        p = $sformatf("row%0d", r);
        load_cfg(v);
        clear_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({p, " start busy/done/flags"}, {busy, done, tlast_err, timeout_err}, 4'b1000);
        check({p, " start checksum"}, checksum, 0);

        guard = 0;
        while (!done && guard < 4000) begin
            tick();
            guard++;
        end
        check({p, " done"}, done, 1);
        check({p, " busy"}, busy, 0);
        check({p, " wb_count"}, wb_n, v.exp_wb);

        seq_err = 0;
        for (int i = 0; i < wb_n && i < 12; i++) begin
            if (i < N_TAP) begin
                if (wb_adr[i] != 32'h40 + 32'(4 * i) || wb_dat[i] != tap_rom[i]) seq_err++;
            end else if (wb_adr[i] != 32'h20 || wb_dat[i] != 32'h1) begin
                seq_err++;
            end
        end
        check({p, " wb_sequence_errs"}, seq_err, 0);
        check({p, " wb_protocol_errs"}, {wb_stab_err[15:0], wb_gap_err[15:0], wb_sel_err[15:0]}, 0);
        check({p, " ss_beats"}, ss_n, v.exp_ss);
        check({p, " ss_data_errs"}, ss_err, 0);
        check({p, " res_count"}, res_n, v.exp_res);
        check({p, " res_errs"}, res_err, 0);
        check({p, " checksum"}, checksum, exp_sum(v.exp_res));
        check({p, " tlast_err"}, tlast_err, v.exp_tlast);
        check({p, " timeout_err"}, timeout_err, v.exp_to);
        check({p, " idle_handshakes"}, {ss_tvalid, sm_tready, wbs_cyc_i}, 0);
        if (v.exp_ssv >= 0) check({p, " ss_valid_cycles"}, ss_vcyc, v.exp_ssv);
    endtask

    initial begin
        int seed;
        int guard;

        //           ack ssg smg stop caus en bad  wb  ss  res tl to ssv
        vecs[0] = '{  1,  0,  0,  50,  1,  1, -1, 12, 50, 50, 0, 0, -1};
        vecs[1] = '{  5,  3,  4,  50,  1,  1, -1, 12, 50, 50, 0, 0, -1};
        vecs[2] = '{  0,  2,  0,  50,  1,  1, 10, 12, 50, 50, 1, 0, -1};
        vecs[3] = '{  1,  0,  0,   0,  1,  0, -1, 12,  0,  0, 0, 1, 16};
        vecs[4] = '{  2,  4,  3,  50,  1,  1, -1, 12, 50, 50, 0, 0, -1};
        vecs[5] = '{  1,  0,  0,  30,  0,  1, -1, 12, 30, 50, 0, 0, -1};
        vecs[6] = '{  1,  0,  5,  50,  1,  1, 49, 12, 50, 50, 1, 0, -1};
        vecs[7] = '{100,  0,  0,  50,  1,  1, -1,  0,  0,  0, 0, 1,  0};

        seed = 20;
        for (int n = 0; n < DATA_LEN; n++) begin
            xs[n]      = $random(seed) % 300;
            smp_rom[n] = 32'(xs[n]);
        end
        for (int j = 0; j < N_TAP; j++) tap_rom[j] = 32'(taps[j]);
        for (int n = 0; n < DATA_LEN; n++) begin
            int acc;
            acc = 0;
            for (int j = 0; j < N_TAP; j++)
                if (n - j >= 0) acc += taps[j] * xs[n - j];
            gold[n] = 32'(acc);
        end

        rst   = 1'b1;
        start = 1'b0;
        load_cfg(vecs[0]);
        clear_run();
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int r = 0; r < 8; r++) run_case(r, vecs[r]);

        // Reset while tap 4 is on the bus; the next run must restart at tap 0.
        load_cfg(vecs[0]);
        clear_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(wbs_stb_i && wbs_adr_i == 32'h50) && guard < 200) begin
            tick();
            guard++;
        end
        check("mid_rst reached tap4", wbs_adr_i, 32'h50);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        wbs_ack_o = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_case(8, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
